uart_tx_sched: RTL and testbench

Scheduler that shares the single `uart_tx` transmitter between two requesters: a periodic ADC report generator and a receive-echo path. Every report period it snapshots `volt_ch1`/`volt_ch2` and sends an 18-byte ASCII frame. Between frames it echoes bytes from `uart_rx` through a small FIFO. It sits between `ad9238`/`uart_rx` and `uart_tx` in `fpga_slave` and replaces the inline send/wait state machine there.

---
 rtl/fpga_slave_pkg.sv | 58 +++++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_sched.sv | 148 ++++++++++++++
 tb/tb_uart_tx_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_slave_pkg.sv
// Shared types and helpers for the fpga_slave UART report/echo path.
package fpga_slave_pkg;

  // Scheduler states: idle, sending a report frame, or sending one echo byte.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REPORT = 2'd1,
    ST_ECHO   = 2'd2
  } sched_state_e;

  // Bytes per report frame: "AD1:hhh\r\nAD2:hhh\r\n".
  localparam int FRAME_LEN = 18;

  localparam logic [7:0] ASC_A     = 8'h41;
  localparam logic [7:0] ASC_D     = 8'h44;
  localparam logic [7:0] ASC_1     = 8'h31;
  localparam logic [7:0] ASC_2     = 8'h32;
  localparam logic [7:0] ASC_COLON = 8'h3A;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_LF    = 8'h0A;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    if (nib < 4'd10) return 8'h30 + {4'h0, nib};
    else             return 8'h37 + {4'h0, nib};
  endfunction

  // Byte at position idx of the report frame for the given voltages.
  function automatic logic [7:0] frame_byte(input logic [4:0]  idx,
                                            input logic [11:0] v1,
                                            input logic [11:0] v2);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      5'd0:  b = ASC_A;
      5'd1:  b = ASC_D;
      5'd2:  b = ASC_1;
      5'd3:  b = ASC_COLON;
      5'd4:  b = nib2hex(v1[11:8]);
      5'd5:  b = nib2hex(v1[7:4]);
      5'd6:  b = nib2hex(v1[3:0]);
      5'd7:  b = ASC_CR;
      5'd8:  b = ASC_LF;
      5'd9:  b = ASC_A;
      5'd10: b = ASC_D;
      5'd11: b = ASC_2;
      5'd12: b = ASC_COLON;
      5'd13: b = nib2hex(v2[11:8]);
      5'd14: b = nib2hex(v2[7:4]);
      5'd15: b = nib2hex(v2[3:0]);
      5'd16: b = ASC_CR;
      5'd17: b = ASC_LF;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read data and full/empty flags.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between a periodic ADC report frame and an rx echo path.
// Reports take priority; a frame is sent atomically, echo bytes go one at a time.
//
// Handshake toward uart_tx: a byte transfers on a clock edge where
// tx_data_valid and tx_data_ready are both high. Once tx_data_valid rises,
// tx_data holds and tx_data_valid stays high until that transfer (reset aside).
module uart_tx_sched
  import fpga_slave_pkg::*;
#(
  parameter int CLK_FRE    = 100,
  parameter int REPORT_MS  = 1000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        report_en,
  input  logic [11:0] volt_ch1,
  input  logic [11:0] volt_ch2,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_valid,
  output logic [7:0]  tx_data,
  output logic        tx_data_valid,
  input  logic        tx_data_ready,
  output logic        busy,
  output logic        echo_drop,
  output logic        report_ovr
);

  localparam logic [63:0] PERIOD_L = 64'(CLK_FRE) * 64'd1000 * 64'(REPORT_MS);
  localparam logic [31:0] PERIOD   = PERIOD_L[31:0];
  localparam logic [31:0] CNT_LAST = PERIOD - 32'd1;
  localparam logic [4:0]  IDX_LAST = 5'(FRAME_LEN - 1);

  sched_state_e state;
  logic [31:0]  period_cnt;
  logic         tick;
  logic         pend;
  logic         serve;
  logic         handshake;
  logic [4:0]   idx;
  logic [11:0]  snap_v1;
  logic [11:0]  snap_v2;

  logic         fifo_pop;
  logic [7:0]   fifo_dout;
  logic         fifo_full;
  logic         fifo_empty;

  assign tick      = report_en && (period_cnt == CNT_LAST);
  assign serve     = (state == ST_IDLE) && pend;
  assign fifo_pop  = (state == ST_IDLE) && !pend && !fifo_empty;
  assign handshake = tx_data_valid && tx_data_ready;
  assign busy      = (state != ST_IDLE);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_echo_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push    (rx_data_valid),
    .din     (rx_data),
    .pop     (fifo_pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Report period counter; held at zero while reports are disabled.
  always_ff @(posedge sys_clk) begin
    if (sys_rst)         period_cnt <= '0;
    else if (!report_en) period_cnt <= '0;
    else if (tick)       period_cnt <= '0;
    else                 period_cnt <= period_cnt + 32'd1;
  end

  // Pending-report flag; a tick that finds an unserved request flags an overrun.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      pend       <= 1'b0;
      report_ovr <= 1'b0;
    end else begin
      if (tick) begin
        pend <= 1'b1;
        if (pend && !serve) report_ovr <= 1'b1;
      end else if (serve) begin
        pend <= 1'b0;
      end
    end
  end

  // Drop pulse when an rx byte meets a full FIFO that is not draining this cycle.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) echo_drop <= 1'b0;
    else         echo_drop <= rx_data_valid && fifo_full && !fifo_pop;
  end

  // Transmit scheduler: picks report or echo in IDLE and walks the frame.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= ST_IDLE;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      idx           <= 5'd0;
      snap_v1       <= 12'h000;
      snap_v2       <= 12'h000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pend) begin
            state         <= ST_REPORT;
            snap_v1       <= volt_ch1;
            snap_v2       <= volt_ch2;
            idx           <= 5'd0;
            tx_data       <= frame_byte(5'd0, volt_ch1, volt_ch2);
            tx_data_valid <= 1'b1;
          end else if (!fifo_empty) begin
            state         <= ST_ECHO;
            tx_data       <= fifo_dout;
            tx_data_valid <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (handshake) begin
            if (idx == IDX_LAST) begin
              tx_data_valid <= 1'b0;
              state         <= ST_IDLE;
            end else begin
              idx     <= idx + 5'd1;
              tx_data <= frame_byte(idx + 5'd1, snap_v1, snap_v2);
            end
          end
        end
        ST_ECHO: begin
          if (handshake) begin
            tx_data_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          tx_data_valid <= 1'b0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched with a 1000-cycle report period.
module tb_uart_tx_sched;

  logic        sys_clk;
  logic        sys_rst;
  logic        report_en;
  logic [11:0] volt_ch1;
  logic [11:0] volt_ch2;
  logic [7:0]  rx_data;
  logic        rx_data_valid;
  logic [7:0]  tx_data;
  logic        tx_data_valid;
  logic        tx_data_ready;
  logic        busy;
  logic        echo_drop;
  logic        report_ovr;

  int n_vec;
  int n_err;

  uart_tx_sched #(
    .CLK_FRE    (1),
    .REPORT_MS  (1),
    .FIFO_DEPTH (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .report_en     (report_en),
    .volt_ch1      (volt_ch1),
    .volt_ch2      (volt_ch2),
    .rx_data       (rx_data),
    .rx_data_valid (rx_data_valid),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready),
    .busy          (busy),
    .echo_drop     (echo_drop),
    .report_ovr    (report_ovr)
  );

  // Clock and cycle counter
  int cyc;
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor on the falling edge: handshakes, valid edges, stall stability, drops
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int         rise_q[$];
  int         fall_q[$];
  int         stall_err;
  int         drop_cnt;
  logic       prev_valid, prev_ready, prev_rst;
  logic [7:0] prev_data;

  initial begin
    stall_err  = 0;
    drop_cnt   = 0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_rst   = 1'b1;
    prev_data  = 8'h00;
  end

  always @(negedge sys_clk) begin
    if (!sys_rst && tx_data_valid && tx_data_ready) got_q.push_back(tx_data);
    if (tx_data_valid && !prev_valid) rise_q.push_back(cyc);
    if (!tx_data_valid && prev_valid) fall_q.push_back(cyc);
    if (prev_valid && !prev_ready && !prev_rst) begin
      if (!tx_data_valid || tx_data !== prev_data) stall_err++;
    end
    if (echo_drop) drop_cnt++;
    prev_valid = tx_data_valid;
    prev_ready = tx_data_ready;
    prev_rst   = sys_rst;
    prev_data  = tx_data;
  end

  // Driver tasks
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    exp_q.delete();
    rise_q.delete();
    fall_q.delete();
    stall_err = 0;
    drop_cnt  = 0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_data       = b;
    rx_data_valid = 1'b1;
    step();
    rx_data_valid = 1'b0;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s.getc(i));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!tx_data_valid && n < 1100) begin
      step();
      n++;
    end
    if (!tx_data_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: tx_data_valid never rose within %0d cycles", name, n);
    end
  endtask

  // Scoreboard tasks
  task automatic test_reset();
    sys_rst       = 1'b1;
    report_en     = 1'b0;
    volt_ch1      = 12'h000;
    volt_ch2      = 12'h000;
    rx_data       = 8'h00;
    rx_data_valid = 1'b0;
    tx_data_ready = 1'b1;
    repeat (3) step();
    sys_rst = 1'b0;
    step();
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %0h expected 0", tx_data); end
    n_vec++; if (tx_data_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid: got %0b expected 0", tx_data_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_vec++; if (echo_drop !== 1'b0) begin n_err++; $display("FAIL reset_echo_drop: got %0b expected 0", echo_drop); end
    n_vec++; if (report_ovr !== 1'b0) begin n_err++; $display("FAIL reset_report_ovr: got %0b expected 0", report_ovr); end
  endtask

  task automatic test_report_period();
    int c0;
    clear_mon();
    volt_ch1 = 12'h3A7;
    volt_ch2 = 12'h0F0;
    tx_data_ready = 1'b1;
    push_str("AD1:3A7\r\nAD2:0F0\r\n");
    push_str("AD1:3A7\r\nAD2:0F0\r\n");
    report_en = 1'b1;
    c0 = cyc;
    repeat (2030) step();
    report_en = 1'b0;
    n_vec++; if (rise_q.size() !== 2) begin n_err++; $display("FAIL period_frames: got %0d expected 2", rise_q.size()); end
    if (rise_q.size() >= 2 && fall_q.size() >= 2) begin
      n_vec++; if (rise_q[0] - c0 !== 1001) begin n_err++; $display("FAIL period_first_latency: got %0d expected 1001", rise_q[0] - c0); end
      n_vec++; if (rise_q[1] - rise_q[0] !== 1000) begin n_err++; $display("FAIL period_spacing: got %0d expected 1000", rise_q[1] - rise_q[0]); end
      n_vec++; if (fall_q[0] - rise_q[0] !== 18) begin n_err++; $display("FAIL period_contig0: got %0d expected 18", fall_q[0] - rise_q[0]); end
      n_vec++; if (fall_q[1] - rise_q[1] !== 18) begin n_err++; $display("FAIL period_contig1: got %0d expected 18", fall_q[1] - rise_q[1]); end
    end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL period_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL period_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_stall_frame();
    int n;
    clear_mon();
    volt_ch1 = 12'hC05;
    volt_ch2 = 12'h9B1;
    tx_data_ready = 1'b1;
    push_str("AD1:C05\r\nAD2:9B1\r\n");
    report_en = 1'b1;
    wait_valid("stall_start");
    volt_ch1 = 12'h000;
    volt_ch2 = 12'hFFF;
    n = 0;
    while (got_q.size() < 18 && n < 400) begin
      tx_data_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    tx_data_ready = 1'b1;
    report_en = 1'b0;
    repeat (3) step();
    n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL stall_stable: got %0d violations expected 0", stall_err); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL stall_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL stall_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_echo();
    int s;
    clear_mon();
    tx_data_ready = 1'b1;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h0D);
    s = cyc;
    send_rx(8'h55);
    send_rx(8'hAA);
    send_rx(8'h0D);
    repeat (12) step();
    n_vec++; if (rise_q.size() !== 3) begin n_err++; $display("FAIL echo_gaps: got %0d valid pulses expected 3", rise_q.size()); end
    if (rise_q.size() > 0) begin
      n_vec++; if (rise_q[0] - s !== 2) begin n_err++; $display("FAIL echo_latency: got %0d expected 2", rise_q[0] - s); end
    end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL echo_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL echo_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_interleave();
    clear_mon();
    volt_ch1 = 12'h3A7;
    volt_ch2 = 12'h0F0;
    tx_data_ready = 1'b1;
    push_str("AD1:3A7\r\nAD2:0F0\r\n");
    exp_q.push_back(8'h42);
    report_en = 1'b1;
    wait_valid("interleave_start");
    report_en = 1'b0;
    repeat (5) step();
    send_rx(8'h42);
    repeat (30) step();
    if (rise_q.size() >= 2 && fall_q.size() >= 1) begin
      n_vec++; if (!(rise_q[1] > fall_q[0])) begin n_err++; $display("FAIL interleave_order: echo rise %0d not after frame end %0d", rise_q[1], fall_q[0]); end
    end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL interleave_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL interleave_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_fifo_overflow();
    clear_mon();
    volt_ch1 = 12'hFFF;
    volt_ch2 = 12'h000;
    tx_data_ready = 1'b1;
    push_str("AD1:FFF\r\nAD2:000\r\n");
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'h99);
    report_en = 1'b1;
    wait_valid("overflow_start");
    tx_data_ready = 1'b0;
    report_en = 1'b0;
    for (int i = 0; i < 10; i++) send_rx(8'h10 + 8'(i));
    repeat (3) step();
    n_vec++; if (drop_cnt !== 2) begin n_err++; $display("FAIL overflow_drops: got %0d expected 2", drop_cnt); end
    tx_data_ready = 1'b1;
    repeat (18) step();
    send_rx(8'h99);
    repeat (80) step();
    n_vec++; if (drop_cnt !== 2) begin n_err++; $display("FAIL full_push_pop: got %0d drops expected 2", drop_cnt); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL overflow_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL overflow_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_report_ovr();
    int c0;
    clear_mon();
    volt_ch1 = 12'h123;
    volt_ch2 = 12'h456;
    tx_data_ready = 1'b0;
    exp_q.push_back(8'h77);
    push_str("AD1:123\r\nAD2:456\r\n");
    send_rx(8'h77);
    report_en = 1'b1;
    c0 = cyc;
    repeat (1500) step();
    n_vec++; if (report_ovr !== 1'b0) begin n_err++; $display("FAIL ovr_after_one_tick: got %0b expected 0", report_ovr); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL ovr_busy: got %0b expected 1", busy); end
    while (cyc < c0 + 2010) step();
    n_vec++; if (report_ovr !== 1'b1) begin n_err++; $display("FAIL ovr_after_two_ticks: got %0b expected 1", report_ovr); end
    report_en = 1'b0;
    tx_data_ready = 1'b1;
    repeat (60) step();
    n_vec++; if (rise_q.size() !== 2) begin n_err++; $display("FAIL ovr_one_frame: got %0d valid pulses expected 2", rise_q.size()); end
    n_vec++; if (got_q.size() !== exp_q.size()) begin n_err++; $display("FAIL ovr_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_vec++; if (got_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ovr_byte%0d: got %0h expected %0h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midframe();
    tx_data_ready = 1'b1;
    report_en = 1'b1;
    wait_valid("rst_mid_start");
    repeat (3) step();
    sys_rst = 1'b1;
    step();
    n_vec++; if (tx_data_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %0b expected 0", tx_data_valid); end
    n_vec++; if (tx_data !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %0h expected 0", tx_data); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %0b expected 0", busy); end
    n_vec++; if (echo_drop !== 1'b0) begin n_err++; $display("FAIL rst_mid_drop: got %0b expected 0", echo_drop); end
    n_vec++; if (report_ovr !== 1'b0) begin n_err++; $display("FAIL rst_mid_ovr: got %0b expected 0", report_ovr); end
    sys_rst = 1'b0;
    report_en = 1'b0;
    clear_mon();
    repeat (50) step();
    n_vec++; if (got_q.size() !== 0) begin n_err++; $display("FAIL rst_mid_abandon: got %0d bytes expected 0", got_q.size()); end
  endtask

  // Test sequence and final report
  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_report_period();
    test_stall_frame();
    test_echo();
    test_no_interleave();
    test_fifo_overflow();
    test_report_ovr();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
